// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a byte stream before execution.
// Bytes arrive over a valid/ready handshake and are packed big-endian into 32-bit
// words, one memory write per word starting at address 0. The load ends after the
// halt word 32'hFFFFFFFF is written (done) or when the last slot is written
// without a halt word (error).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begin a load (honoured in IDLE, DONE, ERR)
//   byte_in/byte_valid incoming program byte and its qualifier
//   byte_ready         loader accepts a byte this cycle (RECV only)
//   mem_we/mem_addr/mem_wdata  instruction memory write port
//   busy/done/error    load status
//   word_count         words written in the current or last load
module imem_loader #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [31:0]       HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_idx;
  logic [31:0]       shreg;
  logic [31:0]       shreg_nxt;

  // Shift register contents once the current byte is folded in.
  assign shreg_nxt = {shreg[23:0], byte_in};

  // Loader FSM; every output is registered and updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      byte_idx   <= 2'd0;
      shreg      <= 32'd0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          // Fresh load: previous memory contents are simply overwritten.
          if (start) begin
            state      <= RECV;
            addr       <= '0;
            byte_idx   <= 2'd0;
            shreg      <= 32'd0;
            word_count <= '0;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end

        RECV: begin
          if (byte_valid && byte_ready) begin
            shreg    <= shreg_nxt;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Fourth byte: present the completed word during WRITE.
              state      <= WRITE;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
              mem_addr   <= addr;
              mem_wdata  <= shreg_nxt;
            end
          end
        end

        WRITE: begin
          word_count <= word_count + (ADDR_W+1)'(1);
          // Halt word wins over the full-memory condition at the last slot.
          if (shreg == HALT_WORD) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (addr == LAST_ADDR) begin
            state <= ERR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            state      <= RECV;
            addr       <= addr + ADDR_W'(1);
            byte_ready <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: one instance at full depth and one with
// DEPTH=4 for the overflow and last-slot halt boundaries.
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // Full-depth instance
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mem_we, busy, done, error;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] word_count;

  // DEPTH=4 instance
  logic        start4 = 1'b0;
  logic [7:0]  byte_in4 = 8'd0;
  logic        byte_valid4 = 1'b0;
  logic        byte_ready4, mem_we4, busy4, done4, error4;
  logic [1:0]  mem_addr4;
  logic [31:0] mem_wdata4;
  logic [2:0]  word_count4;

  imem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .error(error), .word_count(word_count)
  );

  imem_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .byte_in(byte_in4),
    .byte_valid(byte_valid4), .byte_ready(byte_ready4), .mem_we(mem_we4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .busy(busy4), .done(done4),
    .error(error4), .word_count(word_count4)
  );

  int checks = 0;
  int errors = 0;

  // Write monitors
  logic [9:0]  wa[$];
  logic [31:0] wd[$];
  logic [1:0]  wa4[$];
  logic [31:0] wd4[$];
  int          rdy_during_we = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      if (byte_ready) rdy_during_we++;
    end
    if (mem_we4) begin
      wa4.push_back(mem_addr4);
      wd4.push_back(mem_wdata4);
      if (byte_ready4) rdy_during_we++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start4 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start  = 1'b0;
  endtask

  // Offer one byte; returns at the negedge after the edge that accepted it.
  task automatic send_byte(input bit sel, input logic [7:0] b);
    logic rdy;
    int   t;
    t = 0;
    if (sel) begin byte_in4 = b; byte_valid4 = 1'b1; end
    else     begin byte_in  = b; byte_valid  = 1'b1; end
    forever begin
      rdy = sel ? byte_ready4 : byte_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) break;
      t++;
      if (t > 50) begin
        checks++;
        errors++;
        $error("FAIL byte_timeout: observed no accept expected accept of %0h", b);
        break;
      end
    end
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        if (sel) byte_valid4 = 1'b0; else byte_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      send_byte(sel, w[31-8*i -: 8]);
    end
  endtask

  task automatic idle_inputs;
    byte_valid  = 1'b0;
    byte_valid4 = 1'b0;
  endtask

  logic [31:0] prog [3];

  initial begin
    prog[0] = 32'h0001_1020;
    prog[1] = 32'h0061_1020;
    prog[2] = 32'hFFFF_FFFF;

    // Reset state
    #12;
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_word_count", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE ignores bytes
    byte_valid = 1'b1;
    byte_in = 8'hAA;
    repeat (3) @(negedge clk);
    chk("idle_no_ready", byte_ready, 0);
    byte_valid = 1'b0;

    // Basic load, valid held high
    pulse_start(0);
    chk("start_busy", busy, 1);
    chk("start_ready", byte_ready, 1);
    for (int w = 0; w < 3; w++) send_word(0, prog[w], 1'b0);
    // Now in WRITE for the halt word
    chk("basic_we_last", mem_we, 1);
    chk("basic_ready_in_write", byte_ready, 0);
    chk("basic_addr_last", mem_addr, 2);
    chk("basic_data_last", mem_wdata, 32'hFFFF_FFFF);
    chk("basic_done_not_yet", done, 0);
    idle_inputs();
    @(negedge clk);
    chk("basic_done", done, 1);
    chk("basic_error", error, 0);
    chk("basic_busy", busy, 0);
    chk("basic_word_count", word_count, 3);
    chk("basic_we_drop", mem_we, 0);
    chk("basic_nwrites", wa.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wa.size()) begin
        chk("basic_waddr", wa[i], i);
        chk("basic_wdata", wd[i], prog[i]);
      end
    end
    // DONE ignores bytes
    byte_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("done_no_ready", byte_ready, 0);
    chk("done_no_write", wa.size(), 3);
    byte_valid = 1'b0;

    // Restart after DONE, gapped stream, ignored start in RECV
    wa.delete(); wd.delete();
    pulse_start(0);
    chk("restart_done_clr", done, 0);
    chk("restart_wc_clr", word_count, 0);
    send_word(0, prog[0], 1'b1);
    byte_valid = 1'b0;
    @(negedge clk);
    pulse_start(0);
    chk("recv_start_busy", busy, 1);
    send_word(0, prog[1], 1'b1);
    send_word(0, prog[2], 1'b1);
    idle_inputs();
    @(negedge clk);
    chk("gap_done", done, 1);
    chk("gap_word_count", word_count, 3);
    chk("gap_nwrites", wa.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wa.size()) begin
        chk("gap_waddr", wa[i], i);
        chk("gap_wdata", wd[i], prog[i]);
      end
    end

    // Reset mid-word
    wa.delete(); wd.delete();
    pulse_start(0);
    send_word(0, 32'h1234_5678, 1'b0);
    send_byte(0, 8'hDE);
    send_byte(0, 8'hAD);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", byte_ready, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wc", word_count, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_nwrites", wa.size(), 1);
    wa.delete(); wd.delete();
    pulse_start(0);
    for (int w = 0; w < 3; w++) send_word(0, prog[w], 1'b0);
    idle_inputs();
    @(negedge clk);
    chk("post_rst_nwrites", wa.size(), 3);
    if (wa.size() > 0) chk("post_rst_addr0", wa[0], 0);
    if (wd.size() > 0) chk("post_rst_data0", wd[0], prog[0]);
    chk("post_rst_done", done, 1);

    // DEPTH=4 overflow
    pulse_start(1);
    for (int w = 0; w < 4; w++) send_word(1, 32'h0A0B_0C00 + 32'(w), 1'b0);
    chk("ovf_we_last", mem_we4, 1);
    chk("ovf_addr_last", mem_addr4, 3);
    @(negedge clk);
    chk("ovf_error", error4, 1);
    chk("ovf_done", done4, 0);
    chk("ovf_word_count", word_count4, 4);
    chk("ovf_ready", byte_ready4, 0);
    chk("ovf_busy", busy4, 0);
    byte_in4 = 8'h55;
    repeat (4) @(negedge clk);
    chk("ovf_5th_ready", byte_ready4, 0);
    chk("ovf_nwrites", wa4.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wa4.size()) begin
        chk("ovf_waddr", wa4[i], i);
        chk("ovf_wdata", wd4[i], 32'h0A0B_0C00 + 32'(i));
      end
    end
    idle_inputs();

    // DEPTH=4 halt at last slot, with a NOP word in the stream
    wa4.delete(); wd4.delete();
    pulse_start(1);
    chk("err_clear", error4, 0);
    send_word(1, 32'h0000_0000, 1'b0);
    send_word(1, 32'h1111_2222, 1'b1);
    send_word(1, 32'h3333_4444, 1'b0);
    send_word(1, 32'hFFFF_FFFF, 1'b1);
    idle_inputs();
    @(negedge clk);
    chk("last_done", done4, 1);
    chk("last_error", error4, 0);
    chk("last_word_count", word_count4, 4);
    chk("last_nwrites", wa4.size(), 4);
    if (wd4.size() > 0) chk("last_nop_written", wd4[0], 0);
    if (wa4.size() > 3) chk("last_addr3", wa4[3], 3);

    chk("ready_low_during_we", rdy_during_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the CPU instruction memory before execution. It accepts a byte stream over a valid/ready handshake and packs bytes big-endian into 32-bit words. It issues one write per word to the instruction memory's write port, starting at address 0. Loading stops at the halt word 32'hFFFFFFFF (which is itself written) or with an error when the memory is full. The instruction-fetch side only reads memory, so this block is its writer.

## Interface

Parameters:
- DEPTH, 1024: instruction memory depth in words.
- ADDR_W, 10: address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  single clock; all state changes on posedge clk.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- byte_in  input  8  next program byte; first byte of a word is bits [31:24].
- byte_valid  input  1  byte_in holds a valid byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one cycle per word.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  word to write.
- busy  output  1  high in RECV and WRITE.
- done  output  1  halt word written; held until next start.
- error  output  1  memory filled without a halt word; held until next start.
- word_count  output  ADDR_W+1  number of words written in the current or last load.

## Operation

- The FSM has five states: IDLE, RECV, WRITE, DONE, ERR.
- IDLE:
  - byte_ready=0.
  - start -> RECV; clears addr, byte index, shift register and word_count.
- RECV:
  - byte_ready=1.
  - A byte is accepted only when byte_valid & byte_ready. On accept: shreg <= {shreg[23:0], byte_in} and byte_idx increments (2-bit).
  - Accept with byte_idx==3 -> WRITE.
  - No accept -> state held; there is no timeout.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=addr, mem_wdata=shreg, byte_ready=0.
  - word_count increments.
  - If shreg==32'hFFFFFFFF -> DONE.
  - Else if addr==DEPTH-1 -> ERR.
  - Else addr increments and the FSM returns to RECV.
- DONE:
  - done=1, byte_ready=0.
  - start -> RECV with a fresh load; no clear of memory contents.
- ERR:
  - error=1, byte_ready=0.
  - start -> RECV with a fresh load.
- start in RECV or WRITE is ignored.
- byte_valid in IDLE, DONE or ERR is ignored; no byte is consumed.
- The all-zero word (NOP) is written like any other word and is not a terminator.

## Timing

- Reset values:
  - Outputs: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, word_count=0.
  - Internal: state=IDLE, byte_idx=0, shreg=0.
- Reset asserted mid-load: the FSM returns to IDLE immediately (asynchronous) and mem_we drops. A partially assembled word is discarded and never written.
- mem_we, mem_addr and mem_wdata are registered. mem_we is high in the cycle after the clock edge that accepted the 4th byte.
- byte_ready is a decoded FSM output, high only in RECV. It goes low the cycle after the 4th byte is accepted and returns high the cycle after WRITE.
- Throughput is a minimum of 5 cycles per word: 4 byte cycles plus 1 write cycle.
- Status flags rise on the edge leaving WRITE, one cycle after the final mem_we:
  - done/error set and busy clears.
  - word_count shows its final value in that cycle.
- mem_addr and mem_wdata hold their last values outside WRITE. Only mem_we qualifies a write.
- Overflow boundary: the word at addr DEPTH-1 is written, then the FSM enters ERR. If that word is the halt word, DONE takes priority over ERR.

## Test plan

- Basic load: start, then bytes 00 01 10 20 / 00 61 10 20 / FF FF FF FF with byte_valid held high. Expect:
  - writes of 32'h00011020 @0, 32'h00611020 @1, 32'hFFFFFFFF @2;
  - done=1 and word_count=3;
  - byte_ready low during each WRITE cycle.
- Backpressure/gaps: the same stream with byte_valid toggled 1-0-1 randomly. Expect identical writes and addresses, and no byte dropped or duplicated.
- Reset mid-word: after 2 bytes of word 1, pulse rst_n low. Expect:
  - all outputs at reset values, no mem_we;
  - a following start and full stream writes from addr 0 again.
- Overflow with DEPTH=4: send 4 non-halt words. Expect writes @0..3, then error=1, done=0, word_count=4, byte_ready=0. A 5th byte is not accepted.
- Halt at last slot with DEPTH=4: 3 words plus FFFFFFFF. Expect done=1, error=0, word_count=4.
- start ignored, then restart:
  - start pulsed during RECV leaves the load unaffected;
  - start after DONE clears done and word_count, and the next word is written @0.
